// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
//   Shared types and constants for the RV32I multi-cycle sequencing controller.
//   - ctrl_state_t : sequencing state, encoded as seen on the state output
//   - PC_SRC_*     : program-counter source select codes
//   - ALU_OP_W/SRC_W/WB_W : widths of the decoder control fields
//   - ctrl_latch_t : decoder fields captured in DECODE and held for the
//                    remainder of the instruction
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int ALU_OP_W = 4;
    localparam int SRC_W    = 2;
    localparam int WB_W     = 2;
    localparam int PC_SRC_W = 2;
    localparam int STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } ctrl_state_t;

    localparam logic [PC_SRC_W-1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'b10;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [SRC_W-1:0]    alu_src;
        logic [WB_W-1:0]     wb_sel;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
    } ctrl_latch_t;

    // An instruction the decoder recognised always does at least one of these.
    function automatic logic dec_is_legal(input logic reg_write,
                                          input logic mem_read,
                                          input logic mem_write,
                                          input logic branch,
                                          input logic jump);
        return reg_write | mem_read | mem_write | branch | jump;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//   Bundle between the sequencing controller and the rest of the core.
//   master modport: the controller (consumes decoder/memory status, drives
//                   datapath strobes, latched controls, state and status).
//   slave modport : the surrounding datapath / memory system.
//   Inputs to controller : stall, dec_* (decoder bundle), branch_taken,
//                          imem_ready, dmem_ready
//   Outputs of controller: imem_req, dmem_req, dmem_we, ir_write, pc_write,
//                          pc_src, rf_we, alu_op, alu_src, wb_sel, state,
//                          illegal_instr, bus_error, retired
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    import ctrl_pkg::*;

    logic                stall;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_reg_write;
    logic [SRC_W-1:0]    dec_alu_src;
    logic                dec_mem_read;
    logic                dec_mem_write;
    logic [WB_W-1:0]     dec_mem_to_reg;
    logic                dec_branch;
    logic                dec_jump;
    logic                branch_taken;
    logic                imem_ready;
    logic                dmem_ready;

    logic                imem_req;
    logic                dmem_req;
    logic                dmem_we;
    logic                ir_write;
    logic                pc_write;
    logic [PC_SRC_W-1:0] pc_src;
    logic                rf_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SRC_W-1:0]    alu_src;
    logic [WB_W-1:0]     wb_sel;
    logic [STATE_W-1:0]  state;
    logic                illegal_instr;
    logic                bus_error;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  stall, dec_alu_op, dec_reg_write, dec_alu_src, dec_mem_read,
               dec_mem_write, dec_mem_to_reg, dec_branch, dec_jump,
               branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, rf_we,
               alu_op, alu_src, wb_sel, state, illegal_instr, bus_error, retired
    );

    modport slave (
        output stall, dec_alu_op, dec_reg_write, dec_alu_src, dec_mem_read,
               dec_mem_write, dec_mem_to_reg, dec_branch, dec_jump,
               branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, rf_we,
               alu_op, alu_src, wb_sel, state, illegal_instr, bus_error, retired
    );

endinterface

// File: rtl/multicycle_controller_bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// bus_timeout_counter
//   Counts cycles a memory request has waited for ready. Shared by the
//   instruction fetch and data access phases, which never overlap.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     i_clear     : return the count to zero (wins over i_count_en)
//     i_count_en  : a request is asserted and ready is low this cycle
//     o_expired   : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int               CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LAST)) begin
            // Holding at LAST keeps the count from wrapping if the controller
            // ever stays in a waiting state after expiry.
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Multi-cycle sequencing FSM for the RV32I core. One datapath phase per
//   state: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] -> FETCH.
//   Owns the instruction/data memory request handshakes with a bounded wait,
//   the retired-instruction counter and the sticky bus_error flag.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-high reset (honoured in every state)
//     bus    : multicycle_controller_if.master (decoder bundle, memory
//              handshakes, datapath strobes, latched controls, status)
//   Parameters:
//     TIMEOUT : max cycles a memory request may wait for ready (>= 2)
//     CNT_W   : width of the retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic                             clk,
    input logic                             reset,
    multicycle_controller_if.master         bus
);

    ctrl_state_t      r_state;
    ctrl_latch_t      r_ctl;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_retired;

    logic             w_imem_req;
    logic             w_ir_write;
    logic             w_dmem_req;
    logic             w_dmem_we;
    logic             w_pc_write;
    logic [1:0]       w_pc_src;
    logic             w_rf_we;
    logic             w_illegal;

    logic             w_dec_legal;
    logic             w_waiting;
    logic             w_tmo_clear;
    logic             w_expired;
    logic             w_timeout;

    assign w_dec_legal = dec_is_legal(bus.dec_reg_write, bus.dec_mem_read,
                                      bus.dec_mem_write, bus.dec_branch,
                                      bus.dec_jump);

    // ---------------------------------------------------------------------
    // Timeout tracking. A cycle counts only while a request is actually on
    // the bus with ready low, so stalled FETCH cycles leave the count alone.
    // The count is cleared in every state that is not a request phase and
    // when MEM completes, so it is always zero on entry to FETCH or MEM.
    // ---------------------------------------------------------------------
    assign w_waiting   = (w_imem_req && !bus.imem_ready) ||
                         (w_dmem_req && !bus.dmem_ready);
    assign w_tmo_clear = !((r_state == ST_FETCH) || (r_state == ST_MEM)) ||
                         ((r_state == ST_MEM) && bus.dmem_ready);
    // A ready arriving in the last allowed cycle clears w_waiting, so it wins.
    assign w_timeout   = w_waiting && w_expired;

    bus_timeout_counter #(
        .TIMEOUT    (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_tmo_clear),
        .i_count_en (w_waiting),
        .o_expired  (w_expired)
    );

    // ---------------------------------------------------------------------
    // Datapath strobes: decoded from the current state so the PC, IR and
    // register-file enables can only fire in their own phase. They are held
    // low while reset is asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_imem_req = 1'b0;
        w_ir_write = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_pc_write = 1'b0;
        w_pc_src   = PC_SRC_PC4;
        w_rf_we    = 1'b0;
        w_illegal  = 1'b0;
        if (!reset) begin
            unique case (r_state)
                ST_FETCH: begin
                    w_imem_req = !bus.stall;
                    w_ir_write = !bus.stall && bus.imem_ready;
                end
                ST_DECODE: begin
                    // Unrecognised instruction: skip it and move on to PC+4.
                    if (!w_dec_legal) begin
                        w_illegal  = 1'b1;
                        w_pc_write = 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (r_ctl.branch) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = bus.branch_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
                    end
                end
                ST_MEM: begin
                    w_dmem_req = 1'b1;
                    w_dmem_we  = r_ctl.mem_write;
                    // A store finishes here; a load still has WRITEBACK to go.
                    if (bus.dmem_ready && !r_ctl.mem_read) begin
                        w_pc_write = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    w_rf_we    = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_src   = r_ctl.jump ? PC_SRC_ALU : PC_SRC_PC4;
                end
                default: ;  // HALT: everything stays low
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing FSM with its registered outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; it is checked ahead of
        // the state decode so it wins mid-request as well.
        if (reset) begin
            r_state     <= ST_FETCH;
            r_ctl       <= '0;
            r_bus_error <= 1'b0;
            r_retired   <= '0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (!bus.stall && bus.imem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_state     <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    r_ctl.alu_op    <= bus.dec_alu_op;
                    r_ctl.alu_src   <= bus.dec_alu_src;
                    r_ctl.wb_sel    <= bus.dec_mem_to_reg;
                    r_ctl.mem_read  <= bus.dec_mem_read;
                    r_ctl.mem_write <= bus.dec_mem_write;
                    r_ctl.branch    <= bus.dec_branch;
                    r_ctl.jump      <= bus.dec_jump;
                    r_state         <= w_dec_legal ? ST_EXECUTE : ST_FETCH;
                end
                ST_EXECUTE: begin
                    if (r_ctl.branch) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= ST_FETCH;
                    end else if (r_ctl.mem_read || r_ctl.mem_write) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        if (r_ctl.mem_read) begin
                            r_state <= ST_WRITEBACK;
                        end else begin
                            r_retired <= r_retired + 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_state     <= ST_HALT;
                    end
                end
                ST_WRITEBACK: begin
                    r_retired <= r_retired + 1'b1;
                    r_state   <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;  // only reset leaves HALT
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req      = w_imem_req;
    assign bus.ir_write      = w_ir_write;
    assign bus.dmem_req      = w_dmem_req;
    assign bus.dmem_we       = w_dmem_we;
    assign bus.pc_write      = w_pc_write;
    assign bus.pc_src        = w_pc_src;
    assign bus.rf_we         = w_rf_we;
    assign bus.illegal_instr = w_illegal;
    assign bus.alu_op        = r_ctl.alu_op;
    assign bus.alu_src       = r_ctl.alu_src;
    assign bus.wb_sel        = r_ctl.wb_sel;
    assign bus.state         = r_state;
    assign bus.bus_error     = r_bus_error;
    assign bus.retired       = r_retired;

endmodule
